// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: turns PC-register fetches into SRAM-like bus reads,
// maps kseg0/kseg1 to physical addresses and hands words with their PC to decode.
module inst_fetch_bridge #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter bit          MAP_KSEG = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        ce,
    input  logic        flush,
    input  logic        id_stall,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_stall,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        exc_adel
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state;
    logic        discard;
    logic        stop;
    logic [31:0] buffer;
    logic [31:0] req_pc;
    logic        aligned;
    logic        kseg;
    logic        drop;

    assign aligned   = (pc[1:0] == 2'b00);
    assign kseg      = MAP_KSEG && ((pc[31:29] == 3'b100) || (pc[31:29] == 3'b101));
    assign inst_addr = kseg ? {3'b000, pc[28:0]} : pc;
    assign inst_wr   = 1'b0;
    assign inst_size = 2'b10;

    // A returning word is thrown away if it was flushed, or if fetching was switched off meanwhile.
    assign drop = discard | stop | flush | ~ce;

    always_comb begin
        inst_req   = 1'b0;
        inst_valid = 1'b0;
        exc_adel   = 1'b0;
        if_stall   = 1'b1;
        inst_out   = buffer;
        inst_pc    = req_pc;
        if (!rst) begin
            case (state)
                REQ: begin
                    if (ce) begin
                        if (aligned) begin
                            inst_req = 1'b1;
                        end else begin
                            inst_valid = 1'b1;
                            exc_adel   = 1'b1;
                            inst_out   = 32'h0;
                            inst_pc    = pc;
                            if (!id_stall) if_stall = 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (inst_data_ok && !drop) begin
                        inst_valid = 1'b1;
                        inst_out   = inst_rdata;
                        if (!id_stall) if_stall = 1'b0;
                    end
                end
                HOLD: begin
                    inst_valid = 1'b1;
                    if (!id_stall) if_stall = 1'b0;
                end
                default: ;
            endcase
            // A redirect lets the PC register load its target and kills anything shown to decode.
            if (flush) begin
                inst_valid = 1'b0;
                exc_adel   = 1'b0;
                if_stall   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            discard <= 1'b0;
            stop    <= 1'b0;
            buffer  <= 32'h0;
            req_pc  <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (ce) state <= REQ;
                end
                REQ: begin
                    if (!ce) begin
                        state <= IDLE;
                    end else if (aligned && inst_addr_ok) begin
                        req_pc  <= pc;
                        discard <= flush;
                        stop    <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (inst_data_ok) begin
                        discard <= 1'b0;
                        stop    <= 1'b0;
                        if (drop) begin
                            state <= (stop || !ce) ? IDLE : REQ;
                        end else if (id_stall) begin
                            buffer <= inst_rdata;
                            state  <= HOLD;
                        end else begin
                            state <= REQ;
                        end
                    end else begin
                        if (flush) discard <= 1'b1;
                        if (!ce) stop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush || !id_stall) state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Self-checking bench for inst_fetch_bridge: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a PC/bus reference model.
module tb_inst_fetch_bridge;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        ce;
    logic        flush;
    logic        id_stall;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_stall;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        exc_adel;

    int checks   = 0;
    int failures = 0;

    inst_fetch_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .ce           (ce),
        .flush        (flush),
        .id_stall     (id_stall),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_stall     (if_stall),
        .inst_valid   (inst_valid),
        .inst_out     (inst_out),
        .inst_pc      (inst_pc),
        .exc_adel     (exc_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ce;
        logic [31:0] pc;
        logic        flush;
        logic        id_stall;
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        stall;
        logic        valid;
        logic [31:0] out;
        logic [31:0] ipc;
        logic        adel;
    } vec_t;

    vec_t vecs[21];

    // Physical address from the MIPS segment layout.
    function automatic logic [31:0] phys(input logic [31:0] v);
        if (v >= 32'h8000_0000 && v < 32'ha000_0000) return v - 32'h8000_0000;
        if (v >= 32'ha000_0000 && v < 32'hc000_0000) return v - 32'ha000_0000;
        return v;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic apply_stimulus(input logic r, input logic c, input logic [31:0] p,
                                  input logic f, input logic s, input logic ao,
                                  input logic dok, input logic [31:0] rd);
        @(negedge clk);
        rst          = r;
        ce           = c;
        pc           = p;
        flush        = f;
        id_stall     = s;
        inst_addr_ok = ao;
        inst_data_ok = dok;
        inst_rdata   = rd;
        #2;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] simulation did not finish");
    end

    logic [31:0]  pc_reg;
    logic [31:0]  exp_next;
    logic [31:0]  resp_addr;
    logic [31:0]  target;
    logic         outstanding;
    int unsigned  lat;
    int           consumed;

    initial begin
        rst = 1'b1; ce = 1'b0; pc = 32'hbfc00000; flush = 1'b0; id_stall = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;

        //                 rst ce  pc            fl id ao do rdata           req addr          st vl out            ipc           adel
        vecs[0]  = '{H, L, 32'hbfc00000, L, L, L, L, 32'h0,        L, 32'h1fc00000, H, L, 32'h0,        32'h0,        L};
        vecs[1]  = '{H, L, 32'hbfc00000, L, L, L, L, 32'h0,        L, 32'h1fc00000, H, L, 32'h0,        32'h0,        L};
        vecs[2]  = '{L, H, 32'hbfc00000, L, L, L, L, 32'h0,        L, 32'h1fc00000, H, L, 32'h0,        32'h0,        L};
        vecs[3]  = '{L, H, 32'hbfc00000, L, L, H, L, 32'h0,        H, 32'h1fc00000, H, L, 32'h0,        32'h0,        L};
        vecs[4]  = '{L, H, 32'hbfc00000, L, L, L, H, 32'h3c080001, L, 32'h1fc00000, L, H, 32'h3c080001, 32'hbfc00000, L};
        vecs[5]  = '{L, H, 32'hbfc00004, L, L, H, L, 32'h0,        H, 32'h1fc00004, H, L, 32'h0,        32'h0,        L};
        vecs[6]  = '{L, H, 32'hbfc00004, H, L, L, L, 32'h0,        L, 32'h1fc00004, L, L, 32'h0,        32'h0,        L};
        vecs[7]  = '{L, H, 32'hbfc00380, L, L, L, H, 32'hdeadbeef, L, 32'h1fc00380, H, L, 32'h0,        32'h0,        L};
        vecs[8]  = '{L, H, 32'hbfc00380, L, L, L, L, 32'h0,        H, 32'h1fc00380, H, L, 32'h0,        32'h0,        L};
        vecs[9]  = '{L, H, 32'hbfc00380, L, L, H, L, 32'h0,        H, 32'h1fc00380, H, L, 32'h0,        32'h0,        L};
        vecs[10] = '{L, H, 32'hbfc00380, L, L, L, H, 32'h24090002, L, 32'h1fc00380, L, H, 32'h24090002, 32'hbfc00380, L};
        vecs[11] = '{L, H, 32'hbfc00002, L, H, L, L, 32'h0,        L, 32'h1fc00002, H, H, 32'h0,        32'hbfc00002, H};
        vecs[12] = '{L, H, 32'hbfc00002, L, L, L, L, 32'h0,        L, 32'h1fc00002, L, H, 32'h0,        32'hbfc00002, H};
        vecs[13] = '{L, H, 32'h00400000, L, L, H, L, 32'h0,        H, 32'h00400000, H, L, 32'h0,        32'h0,        L};
        vecs[14] = '{L, H, 32'h00400000, L, L, L, L, 32'h0,        L, 32'h00400000, H, L, 32'h0,        32'h0,        L};
        vecs[15] = '{H, H, 32'h00400000, L, L, L, L, 32'h0,        L, 32'h00400000, H, L, 32'h0,        32'h0,        L};
        vecs[16] = '{L, L, 32'h00400000, L, L, L, L, 32'h0,        L, 32'h00400000, H, L, 32'h0,        32'h0,        L};
        vecs[17] = '{L, L, 32'h00400000, L, L, L, L, 32'h0,        L, 32'h00400000, H, L, 32'h0,        32'h0,        L};
        vecs[18] = '{L, H, 32'h80001000, L, L, L, L, 32'h0,        L, 32'h00001000, H, L, 32'h0,        32'h0,        L};
        vecs[19] = '{L, H, 32'h80001000, L, L, H, L, 32'h0,        H, 32'h00001000, H, L, 32'h0,        32'h0,        L};
        vecs[20] = '{L, H, 32'h80001000, L, L, L, H, 32'h11112222, L, 32'h00001000, L, H, 32'h11112222, 32'h80001000, L};

        for (int i = 0; i < 21; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].ce, vecs[i].pc, vecs[i].flush, vecs[i].id_stall,
                           vecs[i].addr_ok, vecs[i].data_ok, vecs[i].rdata);
            check_bit($sformatf("v%0d_req", i), inst_req, vecs[i].req);
            check_bit($sformatf("v%0d_stall", i), if_stall, vecs[i].stall);
            check_bit($sformatf("v%0d_valid", i), inst_valid, vecs[i].valid);
            check_bit($sformatf("v%0d_adel", i), exc_adel, vecs[i].adel);
            if (vecs[i].req) check_output($sformatf("v%0d_addr", i), inst_addr, vecs[i].addr);
            if (vecs[i].valid) begin
                check_output($sformatf("v%0d_out", i), inst_out, vecs[i].out);
                check_output($sformatf("v%0d_pc", i), inst_pc, vecs[i].ipc);
            end
        end
        check_bit("wr_const", inst_wr, 1'b0);
        check_output("size_const", {30'h0, inst_size}, 32'h2);

        // Slow address handshake: request holds until accepted, one word per request.
        apply_stimulus(H, L, 32'hbfc00100, L, L, L, L, 32'h0);
        apply_stimulus(H, L, 32'hbfc00100, L, L, L, L, 32'h0);
        check_output("rst_inst_pc", inst_pc, 32'hbfc00000);
        check_bit("rst_valid", inst_valid, 1'b0);
        check_bit("rst_stall", if_stall, 1'b1);
        apply_stimulus(L, H, 32'hbfc00100, L, L, L, L, 32'h0);
        check_bit("a_idle_req", inst_req, 1'b0);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(L, H, 32'hbfc00100, L, L, L, L, 32'h0);
            check_bit($sformatf("a_wait_req%0d", k), inst_req, 1'b1);
            check_bit($sformatf("a_wait_stall%0d", k), if_stall, 1'b1);
            check_output($sformatf("a_wait_addr%0d", k), inst_addr, 32'h1fc00100);
        end
        apply_stimulus(L, H, 32'hbfc00100, L, L, H, L, 32'h0);
        check_bit("a_accept_req", inst_req, 1'b1);
        apply_stimulus(L, H, 32'hbfc00100, L, L, L, L, 32'h0);
        check_bit("a_lat_req", inst_req, 1'b0);
        check_bit("a_lat_valid", inst_valid, 1'b0);
        check_bit("a_lat_stall", if_stall, 1'b1);
        apply_stimulus(L, H, 32'hbfc00100, L, L, L, H, 32'h8c010004);
        check_bit("a_ret_valid", inst_valid, 1'b1);
        check_output("a_ret_out", inst_out, 32'h8c010004);
        check_output("a_ret_pc", inst_pc, 32'hbfc00100);
        check_bit("a_ret_stall", if_stall, 1'b0);
        apply_stimulus(L, H, 32'hbfc00104, L, L, L, L, 32'h0);
        check_bit("a_next_valid", inst_valid, 1'b0);
        check_bit("a_next_req", inst_req, 1'b1);

        // Decode back-pressure at data return: word parked and held stable.
        apply_stimulus(L, H, 32'hbfc00104, L, L, H, L, 32'h0);
        check_output("b_addr", inst_addr, 32'h1fc00104);
        apply_stimulus(L, H, 32'hbfc00104, L, H, L, H, 32'haabbccdd);
        check_bit("b_ret_valid", inst_valid, 1'b1);
        check_bit("b_ret_stall", if_stall, 1'b1);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(L, H, 32'hbfc00104, L, H, L, L, $urandom);
            check_bit($sformatf("b_hold_valid%0d", k), inst_valid, 1'b1);
            check_output($sformatf("b_hold_out%0d", k), inst_out, 32'haabbccdd);
            check_output($sformatf("b_hold_pc%0d", k), inst_pc, 32'hbfc00104);
            check_bit($sformatf("b_hold_req%0d", k), inst_req, 1'b0);
            check_bit($sformatf("b_hold_stall%0d", k), if_stall, 1'b1);
        end
        apply_stimulus(L, H, 32'hbfc00104, L, L, L, L, 32'h0);
        check_bit("b_rel_valid", inst_valid, 1'b1);
        check_output("b_rel_out", inst_out, 32'haabbccdd);
        check_bit("b_rel_stall", if_stall, 1'b0);
        apply_stimulus(L, H, 32'hbfc00108, L, L, L, L, 32'h0);
        check_bit("b_next_req", inst_req, 1'b1);
        check_bit("b_next_valid", inst_valid, 1'b0);

        // Fetching switched off while a read is in flight: response dropped, then idle.
        apply_stimulus(L, H, 32'hbfc00108, L, L, H, L, 32'h0);
        apply_stimulus(L, L, 32'hbfc00108, L, L, L, L, 32'h0);
        check_bit("c_off_valid", inst_valid, 1'b0);
        apply_stimulus(L, L, 32'hbfc00108, L, L, L, H, 32'h12345678);
        check_bit("c_drop_valid", inst_valid, 1'b0);
        check_bit("c_drop_stall", if_stall, 1'b1);
        apply_stimulus(L, H, 32'hbfc00108, L, L, L, L, 32'h0);
        check_bit("c_idle_req", inst_req, 1'b0);
        apply_stimulus(L, H, 32'hbfc00108, L, L, L, L, 32'h0);
        check_bit("c_resume_req", inst_req, 1'b1);

        // Randomized run: bench PC register plus a single-outstanding bus slave.
        apply_stimulus(H, L, 32'hbfc00000, L, L, L, L, 32'h0);
        apply_stimulus(H, L, 32'hbfc00000, L, L, L, L, 32'h0);
        pc_reg      = 32'hbfc00000;
        exp_next    = 32'hbfc00000;
        outstanding = 1'b0;
        lat         = 0;
        resp_addr   = 32'h0;
        consumed    = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst          = 1'b0;
            ce           = 1'b1;
            pc           = pc_reg;
            flush        = ($urandom_range(0, 15) == 0);
            id_stall     = ($urandom_range(0, 2) == 0);
            inst_data_ok = outstanding && (lat == 0);
            inst_rdata   = inst_data_ok ? mem_word(resp_addr) : $urandom;
            inst_addr_ok = 1'b0;
            #1;
            inst_addr_ok = inst_req && !outstanding && ($urandom_range(0, 1) == 1);
            #1;
            if (inst_req) check_output("r_addr", inst_addr, phys(pc));
            if (outstanding) check_bit("r_single_req", inst_req, 1'b0);
            if (flush) check_bit("r_flush_valid", inst_valid, 1'b0);
            if (inst_valid && !id_stall && !flush) begin
                check_output("r_pc", inst_pc, exp_next);
                check_output("r_out", inst_out, mem_word(phys(exp_next)));
                check_bit("r_stall", if_stall, 1'b0);
                check_bit("r_adel", exc_adel, 1'b0);
                exp_next = exp_next + 32'd4;
                consumed++;
            end
            if (flush) begin
                target   = $urandom;
                target[1:0] = 2'b00;
                pc_reg   = target;
                exp_next = target;
            end else if (!if_stall && !id_stall) begin
                pc_reg = pc_reg + 32'd4;
            end
            if (inst_data_ok) begin
                outstanding = 1'b0;
            end else if (outstanding) begin
                lat = lat - 1;
            end
            if (inst_addr_ok) begin
                outstanding = 1'b1;
                lat         = $urandom_range(0, 2);
                resp_addr   = inst_addr;
            end
        end
        checks++;
        if (consumed < 50) begin
            failures++;
            $display("[TB] FAIL r_progress actual=%0d required>=50", consumed);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
